decoder_onehot_pipe: RTL and testbench
======================================

// Module: decoder_onehot_pipe
// PURPOSE
//  Parametrised binary-to-one-hot decoder; successor of the fixed 2-to-4 gate-level decoder.
//  Adds a clocked valid/ready pipeline, enable, out-of-range detection and full-throughput skid buffering.
//  Sits between a command/address source and downstream one-hot select consumers (bank/channel selects).
// PARAMETERS
//  SEL_W      2   width of binary select input (1..8)
//  OUT_W      4   one-hot output width; legal range SEL_W+1 .. 2**SEL_W
//  ERR_CNT_W  8   width of error counter (optional feature only)
// PORTS
//  clk         in   1          single clock, rising edge
//  rst         in   1          asynchronous reset, active-high
//  in_valid    in   1          input token valid
//  in_ready    out  1          block can accept a token this cycle
//  in_sel      in   SEL_W      binary code to decode
//  in_en       in   1          0: token passes but decodes to all-zero
//  out_valid   out  1          output token valid
//  out_ready   in   1          downstream accepts output token
//  out_onehot  out  OUT_W      decoded one-hot (or zero) word
//  out_err     out  1          token carried out-of-range code (in_sel >= OUT_W)
//  err_cnt     out  ERR_CNT_W  present only with DECODER_ERR_CNT_EN
// BEHAVIOUR
//  - Reset (async assert, sync release): out_valid=0, out_onehot=0, out_err=0, skid empty, err_cnt=0.
//    A reset mid-operation discards every held token; no token is output after reset release until a new one is accepted.
//  - Transfer: input fires on in_valid&in_ready at clk edge; output fires on out_valid&out_ready.
//  - Latency: accepted token appears on out_* the next cycle. Throughput 1 token/cycle with out_ready=1.
//  - Decode: in_en=1 & in_sel<OUT_W -> out_onehot[in_sel]=1, others 0, out_err=0.
//    in_en=1 & in_sel>=OUT_W -> out_onehot=0, out_err=1.
//    in_en=0 -> out_onehot=0, out_err=0, regardless of in_sel.
//  - Output regs hold stable while out_valid=1 & out_ready=0. out_onehot is 0 whenever out_valid=0.
//  - in_ready = !skid_full; registered-only, no combinational path from out_ready.
//  - State machine (occupancy):
//    EMPTY: out_valid=0; accept -> ONE.
//    ONE:   out reg valid; accept & !out_ready -> FULL (token into skid); !accept & out_ready -> EMPTY;
//           accept & out_ready -> ONE (out reg replaced).
//    FULL:  in_ready=0; out_ready -> ONE (skid moves to out reg same edge).
//  - Simultaneous accept+drain in ONE never loses or duplicates a token; order is strictly FIFO.
//  - in_sel/in_en are sampled only on accept; their value when in_valid=0 is don't-care.
// CONFIGURATION
//  DECODER_ERR_CNT_EN defined: err_cnt port exists; +1 per accepted token with out_err=1, saturating at all-ones;
//    cleared only by rst.
//  DECODER_ERR_CNT_EN undefined: err_cnt port and counter absent; out_err behaviour unchanged.
// STRUCTURE
//  decoder_pkg: occupancy state enum (EMPTY/ONE/FULL), function onehot_of(sel) with range check,
//    token struct {onehot, err}.
//  Sub-module decoder_skid_buf: 2-entry valid/ready register slice carrying the token struct;
//    top does decode + err counter.
// TESTING
//  1 SEL_W=2,OUT_W=4: in_sel=0..3 in_en=1, out_ready=1 -> 0001,0010,0100,1000 one cycle later, out_err=0.
//  2 SEL_W=3,OUT_W=5: in_sel=6 -> out_onehot=00000, out_err=1; err_cnt 0->1 with macro.
//  3 in_en=0, in_sel=2 -> token out, out_onehot=0000, out_err=0.
//  4 out_ready=0, send 3 tokens -> 2 held, in_ready=0 on 3rd; release -> tokens out in order, no loss.
//  5 Stream 100 tokens with out_ready toggling randomly -> scoreboard matches, full rate when out_ready=1.
//  6 rst mid-stream with FULL -> out_valid=0 same cycle, err_cnt=0, first output after release = new token.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared types and decode helpers for the one-hot decoder pipeline.
// Optional error counter in the top is enabled by defining DECODER_ERR_CNT_EN.
package decoder_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } occ_t;

   localparam int MAX_OUT_W = 256;

   // Codes at or above out_w decode to all-zero; out_of_range flags them.
   function automatic logic [MAX_OUT_W-1:0] onehot_of(input logic [7:0] sel, input int out_w);
      logic [MAX_OUT_W-1:0] v;
      v = '0;
      if (int'({24'd0, sel}) < out_w) v[sel] = 1'b1;
      return v;
   endfunction

   function automatic logic out_of_range(input logic [7:0] sel, input int out_w);
      return int'({24'd0, sel}) >= out_w;
   endfunction

endpackage

// File: rtl/decoder_skid_buf.sv
// Two-entry valid/ready register slice; in_ready is a flop, never a function of out_ready.
//
// state | meaning
// EMPTY | nothing held, out_valid=0
// ONE   | output register holds a token, skid empty
// FULL  | output register and skid both hold tokens, in_ready=0
module decoder_skid_buf
   import decoder_pkg::*;
#(
   parameter type T = logic
) (
   input  logic clk,
   input  logic rst,
   input  logic in_valid,
   output logic in_ready,
   input  T     in_data,
   output logic out_valid,
   input  logic out_ready,
   output T     out_data
);

   occ_t state;
   T     skid_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= EMPTY;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_data  <= '0;
         skid_q    <= '0;
      end else begin
         case (state)
            EMPTY: begin
               if (in_valid) begin
                  out_data  <= in_data;
                  out_valid <= 1'b1;
                  state     <= ONE;
               end
            end
            ONE: begin
               if (in_valid && !out_ready) begin
                  skid_q   <= in_data;
                  in_ready <= 1'b0;
                  state    <= FULL;
               end else if (in_valid && out_ready) begin
                  out_data <= in_data;
               end else if (out_ready) begin
                  // Zeroed so the decoded word reads 0 while nothing is valid.
                  out_data  <= '0;
                  out_valid <= 1'b0;
                  state     <= EMPTY;
               end
            end
            FULL: begin
               if (out_ready) begin
                  out_data <= skid_q;
                  in_ready <= 1'b1;
                  state    <= ONE;
               end
            end
            default: begin
               state     <= EMPTY;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
               out_data  <= '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/decoder_onehot_pipe.sv
// Pipelined binary-to-one-hot decoder with enable, range error and skid buffering.
// Define DECODER_ERR_CNT_EN to add the saturating err_cnt output.
module decoder_onehot_pipe
   import decoder_pkg::*;
#(
   parameter int SEL_W     = 2,
   parameter int OUT_W     = 4
`ifdef DECODER_ERR_CNT_EN
   ,
   parameter int ERR_CNT_W = 8
`endif
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [SEL_W-1:0] in_sel,
   input  logic             in_en,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_onehot,
   output logic             out_err
`ifdef DECODER_ERR_CNT_EN
   ,
   output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

   typedef struct packed {
      logic [OUT_W-1:0] onehot;
      logic             err;
   } tok_t;

   tok_t in_tok;
   tok_t out_tok;

   always_comb begin
      in_tok = '0;
      if (in_en) begin
         in_tok.onehot = OUT_W'(onehot_of(8'(in_sel), OUT_W));
         in_tok.err    = out_of_range(8'(in_sel), OUT_W);
      end
   end

   decoder_skid_buf #(.T(tok_t)) u_skid (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_tok),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_tok)
   );

   assign out_onehot = out_tok.onehot;
   assign out_err    = out_tok.err;

`ifdef DECODER_ERR_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_cnt <= '0;
      end else if (in_valid && in_ready && in_tok.err && !(&err_cnt)) begin
         err_cnt <= err_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_decoder_onehot_pipe.sv
// Directed and randomised-stream bench for decoder_onehot_pipe (2-to-4 and 3-to-5 instances).
module tb_decoder_onehot_pipe;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic       a_in_valid, a_in_ready, a_in_en, a_out_valid, a_out_ready, a_out_err;
   logic [1:0] a_in_sel;
   logic [3:0] a_onehot;
   logic       b_in_valid, b_in_ready, b_in_en, b_out_valid, b_out_ready, b_out_err;
   logic [2:0] b_in_sel;
   logic [4:0] b_onehot;
`ifdef DECODER_ERR_CNT_EN
   logic [7:0] a_err_cnt, b_err_cnt;
`endif

   decoder_onehot_pipe #(.SEL_W(2), .OUT_W(4)) dut_a (
      .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
      .in_sel(a_in_sel), .in_en(a_in_en), .out_valid(a_out_valid),
      .out_ready(a_out_ready), .out_onehot(a_onehot), .out_err(a_out_err)
`ifdef DECODER_ERR_CNT_EN
      , .err_cnt(a_err_cnt)
`endif
   );

   decoder_onehot_pipe #(.SEL_W(3), .OUT_W(5)) dut_b (
      .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .in_sel(b_in_sel), .in_en(b_in_en), .out_valid(b_out_valid),
      .out_ready(b_out_ready), .out_onehot(b_onehot), .out_err(b_out_err)
`ifdef DECODER_ERR_CNT_EN
      , .err_cnt(b_err_cnt)
`endif
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference token for the 2-to-4 instance: {err, onehot}.
   function automatic logic [4:0] model_a(input logic [1:0] sel, input logic en);
      logic [4:0] t;
      t = 5'd0;
      if (en) t[sel] = 1'b1;
      return t;
   endfunction

   logic [4:0] sb[$];

   initial begin
      int accepted;
      int cycles;
      logic acc;

      rst = 1'b1;
      a_in_valid = 0; a_in_sel = 0; a_in_en = 0; a_out_ready = 1;
      b_in_valid = 0; b_in_sel = 0; b_in_en = 0; b_out_ready = 1;
      tick(); tick();
      chk("rst_out_valid", 32'(a_out_valid), 32'd0);
      chk("rst_onehot",    32'(a_onehot),    32'd0);
      chk("rst_err",       32'(a_out_err),   32'd0);
      chk("rst_in_ready",  32'(a_in_ready),  32'd1);
`ifdef DECODER_ERR_CNT_EN
      chk("rst_err_cnt",   32'(b_err_cnt),   32'd0);
`endif
      rst = 1'b0;
      tick();

      // Back-to-back decode of every code, one-cycle latency.
      for (int k = 0; k < 4; k++) begin
         a_in_valid = 1; a_in_sel = 2'(k); a_in_en = 1;
         tick();
         chk("t1_valid",  32'(a_out_valid), 32'd1);
         chk("t1_onehot", 32'(a_onehot),    32'd1 << k);
         chk("t1_err",    32'(a_out_err),   32'd0);
      end
      a_in_valid = 0;
      tick();
      chk("t1_idle_valid",  32'(a_out_valid), 32'd0);
      chk("t1_idle_onehot", 32'(a_onehot),    32'd0);

      // Disabled token passes through as all-zero.
      a_in_valid = 1; a_in_sel = 2'd2; a_in_en = 0;
      tick();
      a_in_valid = 0;
      chk("t3_valid",  32'(a_out_valid), 32'd1);
      chk("t3_onehot", 32'(a_onehot),    32'd0);
      chk("t3_err",    32'(a_out_err),   32'd0);
      tick();

      // 3-to-5: code 4 is the last legal one, 6 is out of range.
      b_in_valid = 1; b_in_sel = 3'd4; b_in_en = 1;
      tick();
      chk("t2_sel4_onehot", 32'(b_onehot),  32'h10);
      chk("t2_sel4_err",    32'(b_out_err), 32'd0);
`ifdef DECODER_ERR_CNT_EN
      chk("t2_cnt_before",  32'(b_err_cnt), 32'd0);
`endif
      b_in_sel = 3'd6;
      tick();
      b_in_valid = 0;
      chk("t2_sel6_valid",  32'(b_out_valid), 32'd1);
      chk("t2_sel6_onehot", 32'(b_onehot),    32'd0);
      chk("t2_sel6_err",    32'(b_out_err),   32'd1);
`ifdef DECODER_ERR_CNT_EN
      chk("t2_cnt_after",   32'(b_err_cnt),   32'd1);
`endif
      tick();

      // Backpressure: two tokens held, third refused, then drained in order.
      a_out_ready = 0; a_in_valid = 1; a_in_en = 1; a_in_sel = 2'd1;
      tick();
      chk("t4_ready1", 32'(a_in_ready), 32'd1);
      a_in_sel = 2'd2;
      tick();
      chk("t4_ready2", 32'(a_in_ready), 32'd0);
      chk("t4_hold1",  32'(a_onehot),   32'h2);
      a_in_sel = 2'd3;
      tick();
      chk("t4_ready3", 32'(a_in_ready), 32'd0);
      chk("t4_hold2",  32'(a_onehot),   32'h2);
      a_in_valid = 0; a_out_ready = 1;
      tick();
      chk("t4_second",       32'(a_onehot),    32'h4);
      chk("t4_ready_again",  32'(a_in_ready),  32'd1);
      tick();
      chk("t4_empty",  32'(a_out_valid), 32'd0);
      chk("t4_zero",   32'(a_onehot),    32'd0);

      // Random stream against a FIFO occupancy/scoreboard model.
      accepted = 0;
      cycles = 0;
      while (accepted < 100 && cycles < 2000) begin
         a_in_valid  = ($urandom_range(0, 3) != 0);
         a_in_sel    = 2'($urandom_range(0, 3));
         a_in_en     = ($urandom_range(0, 4) != 0);
         a_out_ready = 1'($urandom_range(0, 1));
         #3;
         chk("t5_in_ready",  32'(a_in_ready),  32'(sb.size() < 2));
         chk("t5_out_valid", 32'(a_out_valid), 32'(sb.size() > 0));
         if (sb.size() > 0)
            chk("t5_token", 32'({a_out_err, a_onehot}), 32'(sb[0]));
         else
            chk("t5_idle_zero", 32'(a_onehot), 32'd0);
         acc = a_in_valid && (sb.size() < 2);
         if (sb.size() > 0 && a_out_ready) void'(sb.pop_front());
         if (acc) begin
            sb.push_back(model_a(a_in_sel, a_in_en));
            accepted++;
         end
         cycles++;
         tick();
      end
      chk("t5_budget", 32'(accepted), 32'd100);
      a_in_valid = 0; a_out_ready = 1;
      tick(); tick(); tick();
      chk("t5_drained", 32'(a_out_valid), 32'd0);
      sb.delete();

      // Reset while both instances are FULL.
      a_out_ready = 0; a_in_valid = 1; a_in_en = 1; a_in_sel = 2'd0;
      b_out_ready = 0; b_in_valid = 1; b_in_en = 1; b_in_sel = 3'd7;
      tick();
      a_in_sel = 2'd1; b_in_sel = 3'd5;
      tick();
      a_in_valid = 0; b_in_valid = 0;
      chk("t6_full", 32'(a_in_ready), 32'd0);
`ifdef DECODER_ERR_CNT_EN
      chk("t6_cnt3", 32'(b_err_cnt), 32'd3);
`endif
      rst = 1'b1;
      #1;
      chk("t6_rst_valid",  32'(a_out_valid), 32'd0);
      chk("t6_rst_onehot", 32'(a_onehot),    32'd0);
      chk("t6_rst_ready",  32'(a_in_ready),  32'd1);
      chk("t6_rst_bvalid", 32'(b_out_valid), 32'd0);
`ifdef DECODER_ERR_CNT_EN
      chk("t6_rst_cnt",    32'(b_err_cnt),   32'd0);
`endif
      tick();
      rst = 1'b0;
      a_out_ready = 1; b_out_ready = 1;
      tick();
      chk("t6_post_idle", 32'(a_out_valid), 32'd0);
      a_in_valid = 1; a_in_sel = 2'd3;
      tick();
      a_in_valid = 0;
      chk("t6_new_valid",  32'(a_out_valid), 32'd1);
      chk("t6_new_onehot", 32'(a_onehot),    32'h8);
      tick();
      chk("t6_no_ghost", 32'(a_out_valid), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
